load_store_unit: RTL and testbench

- Execution-side consumer of the memory half of the reservation station.
- Accepts one issued load/store (op, base, store data, imm, destination tag) and performs it byte-serially on the single-port byte-wide RAM.
- Broadcasts result and tag on the memory result bus, which feeds RS and ROB wake-up.
- One operation in flight; back-pressure via `lsu_busy`.

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: one op in flight, results broadcast on the memory result bus.
// Optional LSU_IO_STALL_EN adds io_buffer_full, which holds store bytes aimed at 0x30000..0x3FFFF.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [4:0]  NOP_OP     = 5'b11111
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause,
`ifdef LSU_IO_STALL_EN
  input  logic                  io_buffer_full,
`endif
  input  logic [4:0]            memory_op,
  input  logic [31:0]           memory_value1,
  input  logic [31:0]           memory_value2,
  input  logic [31:0]           memory_imm,
  input  logic [2:0]            memory_des,
  output logic                  lsu_busy,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  output logic [31:0]           memory_data,
  output logic [2:0]            memory_des_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  typedef enum logic [4:0] {
    OP_LB  = 5'b10010, OP_LH  = 5'b10011, OP_LW = 5'b10100, OP_LBU = 5'b10101,
    OP_LHU = 5'b10110, OP_SB  = 5'b10111, OP_SH = 5'b11000, OP_SW  = 5'b11001
  } op_t;

  state_t                state_q;
  logic                  store_q;
  logic                  sign_q;
  logic [2:0]            nbytes_q;
  logic [2:0]            cnt_q;
  logic [2:0]            des_q;
  logic [31:8]           wdata_q;
  logic [23:0]           rbuf_q;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic                  mem_wr_q;
  logic [7:0]            mem_dout_q;
  logic [31:0]           data_q;
  logic [2:0]            des_out_q;
  logic                  frz_q;
  logic [7:0]            din_hold_q;

  logic                  op_valid_d;
  logic                  op_store_d;
  logic                  op_sign_d;
  logic [2:0]            op_n_d;
  logic [31:0]           ea_d;
  logic [7:0]            din_d;
  logic [7:0]            wbyte_d;
  logic [31:0]           load_d;
  logic                  io_stall;
  logic                  freeze;

`ifdef LSU_IO_STALL_EN
  logic [31:0] a32;
  always_comb begin
    a32      = 32'(mem_a_q);
    io_stall = io_buffer_full && (state_q == ACCESS) && store_q &&
               (a32 >= 32'h0003_0000) && (a32 <= 32'h0003_FFFF);
  end
`else
  assign io_stall = 1'b0;
`endif

  assign freeze = pause | io_stall;

  always_comb begin
    op_valid_d = (memory_op != NOP_OP) && (memory_op >= OP_LB) && (memory_op <= OP_SW);
    op_store_d = (memory_op >= OP_SB);
    op_sign_d  = (memory_op == OP_LB) || (memory_op == OP_LH);
    case (memory_op)
      OP_LB, OP_LBU, OP_SB: op_n_d = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_n_d = 3'd2;
      default:              op_n_d = 3'd4;
    endcase
    ea_d = memory_value1 + memory_imm;
  end

  // A free-running RAM moves on during a stall; the byte owed on release is the one seen as the stall began.
  assign din_d = frz_q ? din_hold_q : mem_din;

  always_comb begin
    case (cnt_q)
      3'd1:    wbyte_d = wdata_q[15:8];
      3'd2:    wbyte_d = wdata_q[23:16];
      default: wbyte_d = wdata_q[31:24];
    endcase
    case (nbytes_q)
      3'd1:    load_d = sign_q ? {{24{din_d[7]}}, din_d} : {24'h0, din_d};
      3'd2:    load_d = sign_q ? {{16{din_d[7]}}, din_d, rbuf_q[7:0]} : {16'h0, din_d, rbuf_q[7:0]};
      default: load_d = {din_d, rbuf_q};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      sign_q     <= 1'b0;
      nbytes_q   <= '0;
      cnt_q      <= '0;
      des_q      <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= '0;
      data_q     <= '0;
      des_out_q  <= '0;
      frz_q      <= 1'b0;
      din_hold_q <= '0;
    end else begin
      frz_q <= freeze;
      if (freeze && !frz_q) din_hold_q <= mem_din;
      if (!freeze) begin
        case (state_q)
          IDLE, DONE: begin
            des_out_q <= '0;
            if (op_valid_d) begin
              state_q    <= ACCESS;
              store_q    <= op_store_d;
              sign_q     <= op_sign_d;
              nbytes_q   <= op_n_d;
              cnt_q      <= 3'd1;
              des_q      <= memory_des;
              wdata_q    <= memory_value2[31:8];
              mem_a_q    <= ea_d[ADDR_WIDTH-1:0];
              mem_wr_q   <= op_store_d;
              mem_dout_q <= memory_value2[7:0];
            end else begin
              state_q  <= IDLE;
              mem_wr_q <= 1'b0;
            end
          end
          ACCESS: begin
            if (!store_q) begin
              case (cnt_q)
                3'd2:    rbuf_q[7:0]   <= din_d;
                3'd3:    rbuf_q[15:8]  <= din_d;
                3'd4:    rbuf_q[23:16] <= din_d;
                default: ;
              endcase
            end
            if (cnt_q == nbytes_q) begin
              mem_wr_q <= 1'b0;
              if (store_q) begin
                state_q   <= DONE;
                data_q    <= '0;
                des_out_q <= des_q;
              end else begin
                state_q <= WAIT;
              end
            end else begin
              mem_a_q    <= mem_a_q + ADDR_WIDTH'(1);
              mem_dout_q <= wbyte_d;
              cnt_q      <= cnt_q + 3'd1;
            end
          end
          WAIT: begin
            data_q    <= load_d;
            des_out_q <= des_q;
            state_q   <= DONE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign lsu_busy       = (state_q == ACCESS) || (state_q == WAIT);
  assign mem_a          = mem_a_q;
  assign mem_dout       = mem_dout_q;
  assign mem_wr         = mem_wr_q & ~pause & ~io_stall;
  assign memory_data    = data_q;
  assign memory_des_out = des_out_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, hand sequences, and random ops against a byte-array model.
module tb_load_store_unit;

  localparam logic [4:0] LB = 5'b10010, LH = 5'b10011, LW = 5'b10100, LBU = 5'b10101,
                         LHU = 5'b10110, SB = 5'b10111, SH = 5'b11000, SW = 5'b11001,
                         NOP = 5'b11111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pause = 1'b0;
  logic [4:0]  memory_op = NOP;
  logic [31:0] memory_value1 = '0, memory_value2 = '0, memory_imm = '0;
  logic [2:0]  memory_des = '0;
  logic        lsu_busy;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [31:0] memory_data;
  logic [2:0]  memory_des_out;
`ifdef LSU_IO_STALL_EN
  logic        io_buffer_full = 1'b0;
`endif

  load_store_unit #(.ADDR_WIDTH(32), .NOP_OP(5'b11111)) dut (
    .clk(clk), .rst(rst), .pause(pause),
`ifdef LSU_IO_STALL_EN
    .io_buffer_full(io_buffer_full),
`endif
    .memory_op(memory_op), .memory_value1(memory_value1), .memory_value2(memory_value2),
    .memory_imm(memory_imm), .memory_des(memory_des), .lsu_busy(lsu_busy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .memory_data(memory_data), .memory_des_out(memory_des_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [2:0]  des;
    logic [31:0] exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;
  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic int nbytes(input logic [4:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  function automatic bit is_st(input logic [4:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic [31:0] model_load(input logic [4:0] op, input logic [31:0] ea);
    logic [31:0] val;
    int n;
    n = nbytes(op);
    val = '0;
    for (int i = 0; i < n; i++) val = val | (32'(ref_rd(ea + 32'(i))) << (8 * i));
    if ((op == LB || op == LH) && val[8*n-1]) val = val | ~((32'd1 << (8 * n)) - 32'd1);
    return val;
  endfunction

  task automatic model_store(input vec_t v);
    logic [31:0] ea;
    ea = v.v1 + v.imm;
    for (int i = 0; i < nbytes(v.op); i++) ref_mem[ea + 32'(i)] = 8'((v.v2 >> (8 * i)) & 32'hFF);
  endtask

  // Synchronous RAM: read data returns one cycle after the address, free-running through stalls.
  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) begin
      ram[mem_a] = mem_dout;
      wr_count++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Issue v at the current (post-negedge) time and check every cycle up to and including its broadcast cycle.
  task automatic run_op(input vec_t v, input int pause_at, input int pause_len, input string tag);
    logic [31:0] ea;
    int n, L, j, pc;
    bit st;
    ea = v.v1 + v.imm;
    n  = nbytes(v.op);
    st = is_st(v.op);
    L  = st ? n + 1 : n + 2;
    j  = 1;
    pc = 0;
    memory_op = v.op; memory_value1 = v.v1; memory_value2 = v.v2;
    memory_imm = v.imm; memory_des = v.des;
    @(posedge clk);
    @(negedge clk);
    memory_op = NOP;
    while (j <= L) begin
      pause = (j == pause_at) && (pc < pause_len);
      #1;
      if (pause) begin
        chk($sformatf("%s c%0d paused wr", tag, j), 32'(mem_wr), 32'd0);
        chk($sformatf("%s c%0d paused busy", tag, j), 32'(lsu_busy), 32'(j < L));
        pc++;
        @(negedge clk);
      end else begin
        if (j <= n) begin
          chk($sformatf("%s c%0d busy", tag, j), 32'(lsu_busy), 32'd1);
          chk($sformatf("%s c%0d addr", tag, j), mem_a, ea + 32'(j - 1));
          chk($sformatf("%s c%0d wr", tag, j), 32'(mem_wr), 32'(st));
          if (st) chk($sformatf("%s c%0d dout", tag, j), 32'(mem_dout), (v.v2 >> (8 * (j - 1))) & 32'hFF);
        end else if (j < L) begin
          chk($sformatf("%s wait busy", tag), 32'(lsu_busy), 32'd1);
          chk($sformatf("%s wait wr", tag), 32'(mem_wr), 32'd0);
        end
        if (j < L) begin
          chk($sformatf("%s c%0d tag", tag, j), 32'(memory_des_out), 32'd0);
          @(negedge clk);
        end else begin
          chk($sformatf("%s done tag", tag), 32'(memory_des_out), 32'(v.des));
          chk($sformatf("%s done data", tag), memory_data, v.exp);
          chk($sformatf("%s done busy", tag), 32'(lsu_busy), 32'd0);
          chk($sformatf("%s done wr", tag), 32'(mem_wr), 32'd0);
        end
        j++;
      end
    end
  endtask

  task automatic idle_check(input string tag, input logic [31:0] last);
    @(negedge clk);
    #1;
    chk({tag, " idle tag"}, 32'(memory_des_out), 32'd0);
    chk({tag, " idle busy"}, 32'(lsu_busy), 32'd0);
    chk({tag, " idle wr"}, 32'(mem_wr), 32'd0);
    chk({tag, " idle data"}, memory_data, last);
  endtask

  vec_t tbl[$];
  vec_t v;
  int wc;
  logic [4:0] codes [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
  logic [4:0] bad [3] = '{NOP, 5'b00000, 5'b11010};

  initial begin
    @(negedge clk);
    #1;
    chk("reset busy", 32'(lsu_busy), 32'd0);
    chk("reset wr", 32'(mem_wr), 32'd0);
    chk("reset addr", mem_a, 32'd0);
    chk("reset dout", 32'(mem_dout), 32'd0);
    chk("reset data", memory_data, 32'd0);
    chk("reset tag", 32'(memory_des_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset asserted in the middle of a word store.
    memory_op = SW; memory_value1 = 32'h300; memory_imm = '0; memory_value2 = 32'h1122_3344; memory_des = 3'd3;
    @(posedge clk);
    @(negedge clk);
    memory_op = NOP;
    @(negedge clk);
    #1;
    chk("mid-SW k2 wr", 32'(mem_wr), 32'd1);
    chk("mid-SW k2 addr", mem_a, 32'h301);
    chk("mid-SW k2 dout", 32'(mem_dout), 32'h33);
    wc = wr_count;
    rst = 1'b0;
    #1;
    chk("async rst wr", 32'(mem_wr), 32'd0);
    chk("async rst busy", 32'(lsu_busy), 32'd0);
    chk("async rst tag", 32'(memory_des_out), 32'd0);
    chk("async rst addr", mem_a, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-rst busy %0d", i), 32'(lsu_busy), 32'd0);
      chk($sformatf("post-rst tag %0d", i), 32'(memory_des_out), 32'd0);
    end
    chk("post-rst write count", 32'(wr_count), 32'(wc));
    chk("post-rst ram 0x300", 32'(ram_rd(32'h300)), 32'h44);
    chk("post-rst ram 0x301", 32'(ram_rd(32'h301)), 32'h00);
    ref_mem[32'h300] = 8'h44;

    foreach (bad[i]) begin
      memory_op = bad[i];
      @(negedge clk);
      #1;
      chk($sformatf("ignored op %b busy", bad[i]), 32'(lsu_busy), 32'd0);
    end
    memory_op = NOP;
    chk("ignored ops write count", 32'(wr_count), 32'(wc));

    tbl.push_back('{SW,  32'h100,      32'hDEAD_BEEF, 32'h4,         3'd3, 32'h0});
    tbl.push_back('{LB,  32'h104,      32'h0,         32'h0,         3'd5, 32'hFFFF_FFEF});
    tbl.push_back('{LBU, 32'h104,      32'h0,         32'h0,         3'd1, 32'h0000_00EF});
    tbl.push_back('{LH,  32'h100,      32'h0,         32'h5,         3'd2, 32'hFFFF_ADBE});
    tbl.push_back('{LHU, 32'h106,      32'h0,         32'h0,         3'd4, 32'h0000_DEAD});
    tbl.push_back('{LW,  32'h104,      32'h0,         32'h0,         3'd6, 32'hDEAD_BEEF});
    tbl.push_back('{SB,  32'hFFFF_FFFF, 32'h0000_0034, 32'h0,        3'd4, 32'h0});
    tbl.push_back('{SB,  32'h10,       32'h0000_0082, 32'hFFFF_FFF0, 3'd7, 32'h0});
    tbl.push_back('{LH,  32'hFFFF_FFFF, 32'h0,        32'h0,         3'd6, 32'hFFFF_8234});
    tbl.push_back('{LW,  32'h103,      32'h0,         32'h0,         3'd7, 32'hADBE_EF00});
    tbl.push_back('{SH,  32'h200,      32'h1234_5678, 32'h0,         3'd0, 32'h0});
    tbl.push_back('{LHU, 32'h200,      32'h0,         32'h0,         3'd0, 32'h0000_5678});
    tbl.push_back('{LH,  32'h201,      32'h0,         32'h0,         3'd2, 32'h0000_0056});
    tbl.push_back('{LB,  32'h107,      32'h0,         32'h0,         3'd1, 32'hFFFF_FFDE});
    foreach (tbl[i]) begin
      run_op(tbl[i], 0, 0, $sformatf("vec%0d", i));
      if (is_st(tbl[i].op)) model_store(tbl[i]);
      idle_check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Load paused for three cycles on its second byte.
    v = '{LW, 32'h104, 32'h0, 32'h0, 3'd5, 32'hDEAD_BEEF};
    run_op(v, 2, 3, "paused LW");
    idle_check("paused LW", v.exp);

    // Load issued in the store's broadcast cycle.
    v = '{SB, 32'h400, 32'h0000_00A5, 32'h0, 3'd2, 32'h0};
    run_op(v, 0, 0, "b2b SB");
    model_store(v);
    v = '{LW, 32'h400, 32'h0, 32'h0, 3'd3, 32'h0000_00A5};
    run_op(v, 0, 0, "b2b LW");
    idle_check("b2b LW", v.exp);

    for (int i = 0; i < 80; i++) begin
      int pat, plen, L;
      v.op  = codes[$urandom_range(0, 7)];
      v.v1  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                          : 32'h1000 + 32'($urandom_range(0, 24));
      v.imm = 32'($urandom_range(0, 7));
      v.v2  = $urandom;
      v.des = 3'($urandom_range(0, 7));
      v.exp = is_st(v.op) ? 32'h0 : model_load(v.op, v.v1 + v.imm);
      L = is_st(v.op) ? nbytes(v.op) + 1 : nbytes(v.op) + 2;
      pat = 0;
      plen = 0;
      if ($urandom_range(0, 3) == 0) begin
        pat  = $urandom_range(1, L);
        plen = $urandom_range(1, 3);
      end
      run_op(v, pat, plen, $sformatf("rnd%0d", i));
      if (is_st(v.op)) model_store(v);
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", i), v.exp);
    end

    foreach (ref_mem[a]) chk($sformatf("ram[%08h]", a), 32'(ram_rd(a)), 32'(ref_mem[a]));
    foreach (ram[a]) chk($sformatf("stray ram[%08h]", a), 32'(ram[a]), 32'(ref_rd(a)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
